// File: rtl/branch_redirect_ctrl.sv
// Branch redirect sequencer: turns a taken MEM-stage branch into pipeline
// flushes, a PC hold and a valid/ready redirect to fetch, and counts branches.
module branch_redirect_ctrl #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_valid,
  input  logic              stall_mem,
  input  logic              branch_flag,
  input  logic              pc_src,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              if_ready,
  input  logic              cnt_clr,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              hold_pc,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic              flush_ex_mem,
  output logic [CNT_W-1:0]  branch_cnt,
  output logic [CNT_W-1:0]  taken_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FLUSH = 2'd1,
    S_WAIT  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e              state_q, state_d;
  logic                busy_q, busy_d;
  logic                deep_q, deep_d;
  logic [ADDR_W-1:0]   redirect_pc_q, redirect_pc_d;
  logic [CNT_W-1:0]    branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0]    taken_cnt_q, taken_cnt_d;
  logic                resolve_c;

  // Branch resolutions only matter while idle; anything else is dropped.
  assign resolve_c = (state_q == S_IDLE) & mem_valid & ~stall_mem & branch_flag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      busy_q        <= 1'b0;
      deep_q        <= 1'b0;
      redirect_pc_q <= '0;
      branch_cnt_q  <= '0;
      taken_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      busy_q        <= busy_d;
      deep_q        <= deep_d;
      redirect_pc_q <= redirect_pc_d;
      branch_cnt_q  <= branch_cnt_d;
      taken_cnt_q   <= taken_cnt_d;
    end
  end

  // Next state; output flops are loaded from the next state so they track it exactly.
  always_comb begin
    state_d       = state_q;
    redirect_pc_d = redirect_pc_q;
    case (state_q)
      S_IDLE: begin
        if (resolve_c && pc_src) begin
          state_d       = S_FLUSH;
          redirect_pc_d = branch_target;
        end
      end
      S_FLUSH: state_d = if_ready ? S_IDLE : S_WAIT;
      S_WAIT:  if (if_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    deep_d = (state_d == S_FLUSH);
  end

  // Saturating statistics; clear wins over a same-cycle increment.
  always_comb begin
    branch_cnt_d = branch_cnt_q;
    taken_cnt_d  = taken_cnt_q;
    if (cnt_clr) begin
      branch_cnt_d = '0;
      taken_cnt_d  = '0;
    end else if (resolve_c) begin
      if (branch_cnt_q != CNT_MAX) branch_cnt_d = branch_cnt_q + CNT_W'(1);
      if (pc_src && (taken_cnt_q != CNT_MAX)) taken_cnt_d = taken_cnt_q + CNT_W'(1);
    end
  end

  assign redirect_valid = busy_q;
  assign hold_pc        = busy_q;
  assign flush_if_id    = busy_q;
  assign flush_id_ex    = deep_q;
  assign flush_ex_mem   = deep_q;
  assign redirect_pc    = redirect_pc_q;
  assign branch_cnt     = branch_cnt_q;
  assign taken_cnt      = taken_cnt_q;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Bench for branch_redirect_ctrl: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a transaction-level model.
module tb_branch_redirect_ctrl;
  localparam int unsigned AW = 32;
  localparam int unsigned CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mem_valid, stall_mem, branch_flag, pc_src, if_ready, cnt_clr;
  logic [AW-1:0] branch_target;
  logic          redirect_valid, hold_pc, flush_if_id, flush_id_ex, flush_ex_mem;
  logic [AW-1:0] redirect_pc;
  logic [CW-1:0] branch_cnt, taken_cnt;

  int total = 0;
  int bad   = 0;

  branch_redirect_ctrl #(.ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .mem_valid(mem_valid), .stall_mem(stall_mem),
    .branch_flag(branch_flag), .pc_src(pc_src), .branch_target(branch_target),
    .if_ready(if_ready), .cnt_clr(cnt_clr), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .hold_pc(hold_pc), .flush_if_id(flush_if_id),
    .flush_id_ex(flush_id_ex), .flush_ex_mem(flush_ex_mem),
    .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a redirect is an outstanding transaction; its first cycle is the deep flush.
  bit            m_busy, m_first;
  logic [AW-1:0] m_pc;
  int            m_bc, m_tc, m_hs, hs_seen;

  initial begin
    m_hs    = 0;
    hs_seen = 0;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy  = 0;
      m_first = 0;
      m_pc    = '0;
      m_bc    = 0;
      m_tc    = 0;
    end else begin
      bit ev;
      ev = mem_valid && !stall_mem && branch_flag && !m_busy;
      if (cnt_clr) begin
        m_bc = 0;
        m_tc = 0;
      end else if (ev) begin
        m_bc = (m_bc < CMAX) ? m_bc + 1 : CMAX;
        if (pc_src) m_tc = (m_tc < CMAX) ? m_tc + 1 : CMAX;
      end
      if (m_busy) begin
        m_first = 0;
        if (if_ready) begin
          m_busy = 0;
          m_hs++;
        end
      end else if (ev && pc_src) begin
        m_busy  = 1;
        m_first = 1;
        m_pc    = branch_target;
      end
    end
  end

  always @(posedge clk) begin
    if (rst_n && redirect_valid && if_ready) hs_seen++;
  end

  always @(negedge clk) begin
    chk("m_valid",   32'(redirect_valid), 32'(m_busy));
    chk("m_hold",    32'(hold_pc),        32'(m_busy));
    chk("m_fl_ifid", 32'(flush_if_id),    32'(m_busy));
    chk("m_fl_idex", 32'(flush_id_ex),    32'(m_busy && m_first));
    chk("m_fl_exm",  32'(flush_ex_mem),   32'(m_busy && m_first));
    chk("m_pc",      redirect_pc,         m_pc);
    chk("m_bcnt",    32'(branch_cnt),     32'(m_bc));
    chk("m_tcnt",    32'(taken_cnt),      32'(m_tc));
    chk("m_hs",      32'(hs_seen),        32'(m_hs));
  end

  task automatic step(input logic mv, input logic st, input logic bf, input logic ps,
                      input logic [31:0] tgt, input logic rdy, input logic clr);
    @(negedge clk);
    mem_valid     = mv;
    stall_mem     = st;
    branch_flag   = bf;
    pc_src        = ps;
    branch_target = tgt;
    if_ready      = rdy;
    cnt_clr       = clr;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic deep, input logic [31:0] pc);
    chk({tag, "_valid"}, 32'(redirect_valid), 32'(v));
    chk({tag, "_hold"},  32'(hold_pc),        32'(v));
    chk({tag, "_ifid"},  32'(flush_if_id),    32'(v));
    chk({tag, "_idex"},  32'(flush_id_ex),    32'(deep));
    chk({tag, "_exm"},   32'(flush_ex_mem),   32'(deep));
    chk({tag, "_pc"},    redirect_pc,         pc);
  endtask

  int hs0;

  initial begin
    rst_n = 1'b0;
    mem_valid = 0; stall_mem = 0; branch_flag = 0; pc_src = 0;
    branch_target = '0; if_ready = 0; cnt_clr = 0;
    repeat (2) @(negedge clk);
    chk_out("rst", 1'b0, 1'b0, 32'h0);
    chk("rst_bcnt", 32'(branch_cnt), 32'h0);
    chk("rst_tcnt", 32'(taken_cnt), 32'h0);
    rst_n = 1'b1;

    // Not-taken then taken with fetch ready
    step(1, 0, 1, 0, 32'h0,   1, 0);
    step(1, 0, 1, 1, 32'h100, 1, 0);
    step(0, 0, 0, 0, 32'h0,   1, 0);
    chk_out("t1_flush", 1'b1, 1'b1, 32'h100);
    chk("t1_bcnt", 32'(branch_cnt), 32'd2);
    chk("t1_tcnt", 32'(taken_cnt), 32'd1);
    step(0, 0, 0, 0, 32'h0, 0, 0);
    chk_out("t1_idle", 1'b0, 1'b0, 32'h100);

    // Backpressure, plus a taken resolve arriving during WAIT
    hs0 = hs_seen;
    step(1, 0, 1, 1, 32'h2000, 0, 0);
    step(0, 0, 0, 0, 32'h0, 0, 0);
    chk_out("t2_flush", 1'b1, 1'b1, 32'h2000);
    step(0, 0, 0, 0, 32'h0, 0, 0);
    chk_out("t2_wait1", 1'b1, 1'b0, 32'h2000);
    step(1, 0, 1, 1, 32'hDEAD, 0, 0);
    chk_out("t2_wait2", 1'b1, 1'b0, 32'h2000);
    step(0, 0, 0, 0, 32'h0, 1, 0);
    chk_out("t2_wait3", 1'b1, 1'b0, 32'h2000);
    chk("t2_tcnt", 32'(taken_cnt), 32'd2);
    chk("t2_bcnt", 32'(branch_cnt), 32'd3);
    step(0, 0, 0, 0, 32'h0, 0, 0);
    chk_out("t2_idle", 1'b0, 1'b0, 32'h2000);
    chk("t2_hs_once", 32'(hs_seen - hs0), 32'd1);

    // Stalled MEM stage is not a resolution
    step(1, 1, 1, 1, 32'h300, 1, 0);
    step(0, 0, 0, 0, 32'h0, 1, 0);
    step(0, 0, 0, 0, 32'h0, 1, 0);
    chk_out("t3_stall", 1'b0, 1'b0, 32'h2000);
    chk("t3_bcnt", 32'(branch_cnt), 32'd3);
    chk("t3_tcnt", 32'(taken_cnt), 32'd2);

    // Saturation, then clear racing a taken resolve
    for (int i = 0; i < 17; i++) step(1, 0, 1, 0, 32'h0, 1, 0);
    step(0, 0, 0, 0, 32'h0, 1, 0);
    chk("t5_sat", 32'(branch_cnt), 32'd15);
    step(1, 0, 1, 1, 32'h400, 1, 1);
    step(0, 0, 0, 0, 32'h0, 1, 0);
    chk_out("t5_flush", 1'b1, 1'b1, 32'h400);
    chk("t5_bclr", 32'(branch_cnt), 32'd0);
    chk("t5_tclr", 32'(taken_cnt), 32'd0);
    step(0, 0, 0, 0, 32'h0, 1, 0);
    chk_out("t5_idle", 1'b0, 1'b0, 32'h400);

    // Asynchronous reset in WAIT, then a normal redirect
    step(1, 0, 1, 1, 32'h500, 0, 0);
    step(0, 0, 0, 0, 32'h0, 0, 0);
    step(0, 0, 0, 0, 32'h0, 0, 0);
    chk_out("t6_wait", 1'b1, 1'b0, 32'h500);
    #2 rst_n = 1'b0;
    #1;
    chk_out("t6_async", 1'b0, 1'b0, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 1, 1, 32'h600, 1, 0);
    step(0, 0, 0, 0, 32'h0, 1, 0);
    chk_out("t6_flush", 1'b1, 1'b1, 32'h600);
    chk("t6_bcnt", 32'(branch_cnt), 32'd1);
    step(0, 0, 0, 0, 32'h0, 1, 0);
    chk_out("t6_idle", 1'b0, 1'b0, 32'h600);

    // Randomized traffic, checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
           ($urandom_range(0, 2) != 0), ($urandom_range(0, 63) == 0));
    end
    repeat (4) step(0, 0, 0, 0, 32'h0, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
